hdmi_capture_ctrl: RTL and testbench

//  Sequences the HDMI-to-FIFO ingest path: starts capture on a frame boundary, gates the ingester enable, and checks frame geometry.

---
 rtl/hdmi_ctrl_pkg.sv | 14 +
 rtl/hdmi_sync_edge.sv | 43 ++++
 rtl/hdmi_capture_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_hdmi_capture_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_ctrl_pkg.sv
// Shared state encoding and default geometry for the HDMI capture controller.
package hdmi_ctrl_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_VS = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  localparam int DEF_H_ACTIVE  = 800;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_HCNT_W    = 12;
  localparam int DEF_VCNT_W    = 11;
  localparam bit DEF_VSYNC_POL = 1'b1;

endpackage

// File: rtl/hdmi_sync_edge.sv
// Registers the TFP401 sync/DE outputs once and derives the vSync-active edge,
// DE falling edge and hSync rising edge, with vSync polarity normalised.
module hdmi_sync_edge #(
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_vSync,
  input  logic i_hSync,
  input  logic i_de,
  output logic o_de,
  output logic o_vsEdge,
  output logic o_deFall,
  output logic o_hsRise
);

  logic vs_q, vs_prev_q, hs_q, hs_prev_q, de_q, de_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      hs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      de_q      <= 1'b0;
      de_prev_q <= 1'b0;
    end else begin
      vs_q      <= (i_vSync == VSYNC_POL);
      vs_prev_q <= vs_q;
      hs_q      <= i_hSync;
      hs_prev_q <= hs_q;
      de_q      <= i_de;
      de_prev_q <= de_q;
    end
  end

  assign o_de     = de_q;
  assign o_vsEdge = vs_q & ~vs_prev_q;
  assign o_deFall = de_prev_q & ~de_q;
  assign o_hsRise = hs_q & ~hs_prev_q;

endmodule

// File: rtl/hdmi_capture_ctrl.sv
// Frame-aligned capture sequencer for the HDMI-to-FIFO ingest path.
// Define HDMI_CAPTURE_STATS_EN to add measured line length / line count / hSync count outputs.
module hdmi_capture_ctrl
  import hdmi_ctrl_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter bit VSYNC_POL = DEF_VSYNC_POL,
  parameter int HCNT_W    = DEF_HCNT_W,
  parameter int VCNT_W    = DEF_VCNT_W
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_vSync,
  input  logic i_hSync,
  input  logic i_de,
  input  logic i_fifoFull,
  input  logic i_start,
  input  logic i_stop,
  input  logic i_autoRestart,
  output logic o_hdmiEnable,
  output logic o_frameStart,
  output logic o_frameDone,
  output logic o_frameError,
  output logic o_overflow,
  output logic o_busy
`ifdef HDMI_CAPTURE_STATS_EN
  ,
  output logic [HCNT_W-1:0] o_measHActive,
  output logic [VCNT_W-1:0] o_measVActive,
  output logic [VCNT_W-1:0] o_measHsyncs
`endif
);

  localparam logic [HCNT_W-1:0] H_LEN   = HCNT_W'(H_ACTIVE);
  localparam logic [VCNT_W-1:0] V_LINES = VCNT_W'(V_ACTIVE);

  // The 24->32 packer needs whole 4-pixel groups per frame.
  if ((H_ACTIVE * V_ACTIVE) % 4 != 0) begin : g_geom_chk
    $error("hdmi_capture_ctrl: H_ACTIVE*V_ACTIVE must be a multiple of 4");
  end

  logic de_r, vs_edge, de_fall, hs_rise;

  hdmi_sync_edge #(.VSYNC_POL(VSYNC_POL)) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_vSync (i_vSync),
    .i_hSync (i_hSync),
    .i_de    (i_de),
    .o_de    (de_r),
    .o_vsEdge(vs_edge),
    .o_deFall(de_fall),
    .o_hsRise(hs_rise)
  );

  logic [1:0]        state_q, state_d;
  logic [HCNT_W-1:0] pix_q, pix_d;
  logic [VCNT_W-1:0] line_q, line_d;
  logic err_q, err_d, stop_pend_q, stop_pend_d;
  logic en_q, en_d, fs_q, fs_d, fd_q, fd_d, fe_q, fe_d, ovf_q, ovf_d;
  logic ovf_hit, frame_end;

  assign ovf_hit   = (state_q == CAPTURE) && i_fifoFull && de_r;
  assign frame_end = (state_q == CAPTURE) && vs_edge && !ovf_hit;

  always_comb begin
    // NOTE: defaults first so no branch of the case leaves a variable unassigned (no latches).
    state_d     = state_q;
    pix_d       = pix_q;
    line_d      = line_q;
    err_d       = err_q;
    stop_pend_d = stop_pend_q;
    en_d        = en_q;
    ovf_d       = ovf_q;
    fs_d        = 1'b0;
    fd_d        = 1'b0;
    fe_d        = 1'b0;
    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (i_start) begin
          ovf_d = 1'b0;
          if (!i_stop) state_d = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (vs_edge) begin
          state_d     = CAPTURE;
          en_d        = 1'b1;
          fs_d        = 1'b1;
          pix_d       = '0;
          line_d      = '0;
          err_d       = 1'b0;
          stop_pend_d = 1'b0;
        end else if (i_stop) begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        if (ovf_hit) begin
          // Drop the frame silently; restart only on a vSync to keep packing phase.
          ovf_d       = 1'b1;
          en_d        = 1'b0;
          state_d     = i_autoRestart ? WAIT_VS : IDLE;
          pix_d       = '0;
          line_d      = '0;
          err_d       = 1'b0;
          stop_pend_d = 1'b0;
        end else if (vs_edge) begin
          fd_d   = 1'b1;
          fe_d   = err_q | (line_q != V_LINES);
          pix_d  = '0;
          line_d = '0;
          err_d  = 1'b0;
          if (stop_pend_q) begin
            state_d     = IDLE;
            en_d        = 1'b0;
            stop_pend_d = 1'b0;
          end else begin
            fs_d        = 1'b1;
            stop_pend_d = i_stop;
          end
        end else begin
          if (de_fall) begin
            if (pix_q != H_LEN) err_d = 1'b1;
            if (line_q == '1) err_d = 1'b1;
            else              line_d = line_q + VCNT_W'(1);
            pix_d = '0;
          end else if (de_r) begin
            if (pix_q == '1) err_d = 1'b1;
            else             pix_d = pix_q + HCNT_W'(1);
          end
          if (i_stop) stop_pend_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      line_q      <= '0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      en_q        <= 1'b0;
      fs_q        <= 1'b0;
      fd_q        <= 1'b0;
      fe_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
      en_q        <= en_d;
      fs_q        <= fs_d;
      fd_q        <= fd_d;
      fe_q        <= fe_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_hdmiEnable = en_q;
  assign o_frameStart = fs_q;
  assign o_frameDone  = fd_q;
  assign o_frameError = fe_q;
  assign o_overflow   = ovf_q;
  assign o_busy       = (state_q != IDLE);

`ifdef HDMI_CAPTURE_STATS_EN
  logic [HCNT_W-1:0] last_len_q, meas_h_q;
  logic [VCNT_W-1:0] hs_cnt_q, meas_v_q, meas_hs_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      last_len_q <= '0;
      meas_h_q   <= '0;
      hs_cnt_q   <= '0;
      meas_v_q   <= '0;
      meas_hs_q  <= '0;
    end else begin
      if (state_q != CAPTURE || ovf_hit) begin
        hs_cnt_q <= '0;
      end else if (frame_end) begin
        meas_h_q  <= last_len_q;
        meas_v_q  <= line_q;
        meas_hs_q <= hs_cnt_q;
        hs_cnt_q  <= '0;
      end else if (hs_rise && hs_cnt_q != '1) begin
        hs_cnt_q <= hs_cnt_q + VCNT_W'(1);
      end
      if (state_q == CAPTURE && de_fall && !ovf_hit && !vs_edge) last_len_q <= pix_q;
    end
  end

  assign o_measHActive = meas_h_q;
  assign o_measVActive = meas_v_q;
  assign o_measHsyncs  = meas_hs_q;
`else
  logic unused_hs_rise;
  assign unused_hs_rise = hs_rise;
`endif

endmodule

// File: tb/tb_hdmi_capture_ctrl.sv
// Self-checking bench for hdmi_capture_ctrl using a reduced 16x6 geometry.
module tb_hdmi_capture_ctrl;

  localparam int H      = 16;
  localparam int V      = 6;
  localparam int HW     = 5;
  localparam int VW     = 4;
  localparam int HBLANK = 6;
  localparam int HSAT   = (1 << HW) - 1;

  logic clk = 1'b0;
  logic rst, vs, hs, de, full, start, stop, autor;
  logic en, fstart, fdone, ferr, ovf, busy;
`ifdef HDMI_CAPTURE_STATS_EN
  logic [HW-1:0] m_h;
  logic [VW-1:0] m_v, m_hs;
`endif

  always #5 clk = ~clk;

  hdmi_capture_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_POL(1'b1), .HCNT_W(HW), .VCNT_W(VW)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_vSync      (vs),
    .i_hSync      (hs),
    .i_de         (de),
    .i_fifoFull   (full),
    .i_start      (start),
    .i_stop       (stop),
    .i_autoRestart(autor),
    .o_hdmiEnable (en),
    .o_frameStart (fstart),
    .o_frameDone  (fdone),
    .o_frameError (ferr),
    .o_overflow   (ovf),
    .o_busy       (busy)
`ifdef HDMI_CAPTURE_STATS_EN
    ,
    .o_measHActive(m_h),
    .o_measVActive(m_v),
    .o_measHsyncs (m_hs)
`endif
  );

  int n_pass   = 0;
  int n_checks = 0;
  int starts   = 0;
  int dones    = 0;
  bit last_err = 1'b0;
  logic ovf_en, ovf_flag;

  // Pulse monitor on the inactive edge: each one-cycle pulse is seen exactly once.
  always @(negedge clk) begin
    if (fstart) starts++;
    if (fdone) begin
      dones++;
      last_err = ferr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int len, input int full_at);
    for (int p = 0; p < len; p++) begin
      de   = 1'b1;
      full = (p == full_at);
      tick();
      if (p == full_at) begin
        ovf_en   = en;
        ovf_flag = ovf;
      end
    end
    full = 1'b0;
    de   = 1'b0;
    for (int b = 0; b < HBLANK; b++) begin
      hs = (b >= 1 && b < 3);
      tick();
    end
    hs = 1'b0;
  endtask

  task automatic send_frame(input int n_lines, input int short_idx, input int short_len);
    for (int l = 0; l < n_lines; l++) send_line((l == short_idx) ? short_len : H, -1);
  endtask

  task automatic send_vsync();
    vs = 1'b1;
    repeat (3) tick();
    vs = 1'b0;
    repeat (3) tick();
  endtask

  typedef struct {
    int n_lines;
    int short_idx;
    int short_len;
    bit exp_err;
  } frame_vec_t;

  frame_vec_t vecs[8];

  initial begin
    int d0, s0, n_lines, len, last_len;
    bit exp_err;

    vecs[0] = '{V,     -1, H,      1'b0};
    vecs[1] = '{V,      2, H - 1,  1'b1};
    vecs[2] = '{V,     -1, H,      1'b0};
    vecs[3] = '{V,      0, H + 1,  1'b1};
    vecs[4] = '{V - 1, -1, H,      1'b1};
    vecs[5] = '{V + 1, -1, H,      1'b1};
    vecs[6] = '{V,      5, 40,     1'b1};
    vecs[7] = '{V,     -1, H,      1'b0};

    rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0; full = 1'b0;
    start = 1'b0; stop = 1'b0; autor = 1'b0;
    repeat (3) tick();
    check("reset en", en, 0);
    check("reset frameStart", fstart, 0);
    check("reset frameDone", fdone, 0);
    check("reset frameError", ferr, 0);
    check("reset overflow", ovf, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    tick();
    check("idle busy", busy, 0);

    // Start, then exact vSync-to-enable latency
    start = 1'b1; tick(); start = 1'b0;
    check("busy after start", busy, 1);
    check("en before vsync", en, 0);
    vs = 1'b1; tick();
    check("en 1clk after vsync", en, 0);
    tick();
    check("en 2clk after vsync", en, 1);
    check("frameStart with enable", fstart, 1);
    tick();
    check("frameStart one cycle", fstart, 0);
    tick(); vs = 1'b0; repeat (3) tick();

    // Table-driven frame geometry
    foreach (vecs[i]) begin
      d0 = dones;
      send_frame(vecs[i].n_lines, vecs[i].short_idx, vecs[i].short_len);
      send_vsync();
      check($sformatf("vec%0d frameDone count", i), dones - d0, 1);
      check($sformatf("vec%0d frameError", i), last_err, vecs[i].exp_err);
`ifdef HDMI_CAPTURE_STATS_EN
      last_len = (vecs[i].short_idx == vecs[i].n_lines - 1) ? vecs[i].short_len : H;
      check($sformatf("vec%0d measH", i), m_h, (last_len > HSAT) ? HSAT : last_len);
      check($sformatf("vec%0d measV", i), m_v, vecs[i].n_lines);
      check($sformatf("vec%0d measHsyncs", i), m_hs, vecs[i].n_lines);
`endif
    end

    // Randomized frames against the geometry rules
    for (int f = 0; f < 12; f++) begin
      n_lines = V;
      if ($urandom_range(0, 3) == 0) n_lines = ($urandom_range(0, 1) == 1) ? V + 1 : V - 1;
      exp_err  = (n_lines != V);
      last_len = 0;
      d0 = dones;
      for (int l = 0; l < n_lines; l++) begin
        len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : H;
        if (len != H) exp_err = 1'b1;
        last_len = len;
        send_line(len, -1);
      end
      send_vsync();
      check($sformatf("rand%0d frameDone count", f), dones - d0, 1);
      check($sformatf("rand%0d frameError", f), last_err, exp_err);
`ifdef HDMI_CAPTURE_STATS_EN
      check($sformatf("rand%0d measH", f), m_h, (last_len > HSAT) ? HSAT : last_len);
      check($sformatf("rand%0d measV", f), m_v, n_lines);
`endif
    end

    // Overflow with auto-restart
    autor = 1'b1;
    d0 = dones; s0 = starts;
    send_frame(5, -1, H);
    send_line(H, 10);
    check("ovf auto en dropped", ovf_en, 0);
    check("ovf auto flag", ovf_flag, 1);
    check("ovf auto busy", busy, 1);
    send_vsync();
    check("ovf auto no frameDone", dones - d0, 0);
    check("ovf auto recapture", starts - s0, 1);
    check("ovf auto en again", en, 1);
    send_frame(V, -1, H);
    send_vsync();
    check("ovf auto next frameDone", dones - d0, 1);
    check("ovf auto next frameError", last_err, 0);

    // Overflow without auto-restart
    autor = 1'b0;
    s0 = starts;
    send_frame(5, -1, H);
    send_line(H, 10);
    check("ovf idle en dropped", ovf_en, 0);
    check("ovf idle flag", ovf_flag, 1);
    check("ovf idle busy", busy, 0);
    send_vsync();
    check("ovf idle no frameStart", starts - s0, 0);
    check("ovf sticky", ovf, 1);
    start = 1'b1; tick(); start = 1'b0;
    check("ovf cleared by start", ovf, 0);
    check("busy after restart", busy, 1);
    send_vsync();

    // Stop mid-frame takes effect at the next vSync
    send_frame(2, -1, H);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop en held", en, 1);
    send_frame(4, -1, H);
    check("stop en held to vsync", en, 1);
    d0 = dones; s0 = starts;
    send_vsync();
    check("stop frameDone", dones - d0, 1);
    check("stop frameError", last_err, 0);
    check("stop no frameStart", starts - s0, 0);
    check("stop busy", busy, 0);
    check("stop en", en, 0);
    send_frame(V, -1, H);
    send_vsync();
    check("after stop no frameStart", starts - s0, 0);

    // Asynchronous reset mid-line
    start = 1'b1; tick(); start = 1'b0;
    send_vsync();
    de = 1'b1;
    repeat (5) tick();
    check("pre-reset en", en, 1);
    #2 rst = 1'b1;
    #1;
    check("async reset en", en, 0);
    check("async reset busy", busy, 0);
    check("async reset overflow", ovf, 0);
    de = 1'b0;
    tick();
    rst = 1'b0;
    d0 = dones; s0 = starts;
    send_frame(V, -1, H);
    send_vsync();
    send_frame(V, -1, H);
    send_vsync();
    check("post-reset no frameStart", starts - s0, 0);
    check("post-reset no frameDone", dones - d0, 0);
    check("post-reset idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
